// File: rtl/user_uart_pkg.sv
// -----------------------------------------------------------------------------
// user_uart_pkg
// Shared types and constants for the user-area 8N1 UART transmitter.
//   uart_state_e : transmitter FSM states
//   FRAME_BITS   : bits per frame (start + 8 data + stop)
//   DATA_BITS    : payload bits per frame
//   MIN_DIV      : smallest usable clocks-per-bit value
// -----------------------------------------------------------------------------
package user_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int MIN_DIV    = 2;

endpackage

// File: rtl/user_uart_tx_if.sv
// -----------------------------------------------------------------------------
// user_uart_tx_if
// Valid/ready byte push port into the UART transmitter.
//   tx_data  : byte to send            (master -> slave)
//   tx_valid : tx_data is valid        (master -> slave)
//   tx_ready : transmitter FIFO has room (slave -> master)
// A byte transfers on a rising clock edge where tx_valid && tx_ready.
// -----------------------------------------------------------------------------
interface user_uart_tx_if;
  import user_uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/user_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// user_uart_tx_fifo
// Synchronous FIFO with a first-word-fall-through head (o_rdata always shows
// the oldest entry), so a pop can load the consumer on the same edge.
//   clock    : system clock, rising edge
//   resetb   : asynchronous active-low reset; empties the FIFO
//   i_push   : write i_wdata (ignored when full)
//   i_pop    : drop the head entry (ignored when empty)
//   i_wdata  : write data
//   o_rdata  : head entry (valid when !o_empty)
//   o_full   : occupancy == DEPTH
//   o_empty  : occupancy == 0
//   o_level  : current occupancy
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module user_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage is not reset: contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/user_uart_tx.sv
// -----------------------------------------------------------------------------
// user_uart_tx
// Byte-wide 8N1 UART transmitter. Bytes queue in a small FIFO and are sent
// LSB first with one start and one stop bit, each bit lasting div_q clocks.
//   clock      : system clock, rising edge
//   resetb     : asynchronous active-low reset
//   enable     : allows a new frame to start (a running frame always finishes)
//   clk_div    : clocks per bit, sampled at frame start, values < 2 act as 2
//   bus        : valid/ready byte push port (slave side)
//   tx         : serial output, idles high
//   busy       : frame on the line or bytes still queued
//   fifo_level : FIFO occupancy
// -----------------------------------------------------------------------------
module user_uart_tx
  import user_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              clk_div,
  user_uart_tx_if.slave                 bus,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int IDX_W = $clog2(DATA_BITS);

  uart_state_e          r_state;
  logic [DIV_W-1:0]     r_cnt;
  logic [DIV_W-1:0]     r_div_q;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;

  uart_state_e          w_state_next;
  logic [DIV_W-1:0]     w_cnt_next;
  logic [DIV_W-1:0]     w_div_next;
  logic [IDX_W-1:0]     w_bit_idx_next;
  logic [DATA_BITS-1:0] w_shift_next;

  logic [DATA_BITS-1:0] w_fifo_rdata;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [DIV_W-1:0]     w_div_eff;
  logic                 w_cnt_done;
  logic                 w_can_start;

  // tx_ready comes from the registered full flag, so a pop on the same edge
  // cannot open the port until the following cycle.
  assign bus.tx_ready = !w_full;
  assign w_push       = bus.tx_valid && !w_full;

  assign w_div_eff    = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;
  assign w_cnt_done   = (r_cnt == '0);
  assign w_can_start  = enable && !w_empty;

  user_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clock   (clock),
    .resetb  (resetb),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (bus.tx_data),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_div_q   <= DIV_W'(MIN_DIV);
      r_bit_idx <= '0;
      r_shift   <= '1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_div_q   <= w_div_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_div_next     = r_div_q;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_can_start) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_rdata;
          w_div_next   = w_div_eff;
          w_cnt_next   = w_div_eff - DIV_W'(1);
          w_state_next = START;
        end
      end

      START: begin
        if (w_cnt_done) begin
          w_cnt_next     = r_div_q - DIV_W'(1);
          w_bit_idx_next = '0;
          w_state_next   = DATA;
        end else begin
          w_cnt_next = r_cnt - DIV_W'(1);
        end
      end

      DATA: begin
        if (w_cnt_done) begin
          w_cnt_next   = r_div_q - DIV_W'(1);
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
            w_state_next = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt - DIV_W'(1);
        end
      end

      STOP: begin
        if (w_cnt_done) begin
          // Chain straight into the next frame when one is waiting, so
          // consecutive bytes leave no idle gap on the line.
          if (w_can_start) begin
            w_pop        = 1'b1;
            w_shift_next = w_fifo_rdata;
            w_div_next   = w_div_eff;
            w_cnt_next   = w_div_eff - DIV_W'(1);
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - DIV_W'(1);
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Line level is decoded from state and the shift register only, so reset
  // forces it high immediately.
  always_comb begin
    case (r_state)
      START:   tx = 1'b0;
      DATA:    tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (r_state != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_user_uart_tx.sv
module tb_user_uart_tx;
  import user_uart_pkg::*;

  logic        clock = 1'b0;
  logic        resetb;
  logic        enable;
  logic [15:0] clk_div;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_pass   = 0;

  logic rec      [0:511];
  logic rec_busy [0:511];
  int   lvl_max;

  user_uart_tx_if u_bus ();

  user_uart_tx #(
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .enable     (enable),
    .clk_div    (clk_div),
    .bus        (u_bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  // Expected line level for sample i of a frame carrying byte b at d clocks/bit.
  function automatic logic exp_tx(input logic [7:0] b, input int d, input int i);
    int bit_no;
    bit_no = i / d;
    if (bit_no == 0) return 1'b0;
    else if (bit_no <= DATA_BITS) return b[bit_no-1];
    else return 1'b1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      rec[i]      = tx;
      rec_busy[i] = busy;
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      step();
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else n_pass++;
    n_checks++; if (u_bus.tx_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", u_bus.tx_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", fifo_level); else n_pass++;
    resetb = 1'b1;
    step();
    n_checks++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); else n_pass++;
    $display("reset: done");
  endtask

  task automatic test_single();
    int errs;
    logic [7:0] dec;
    enable = 1'b1; clk_div = 16'd8;
    u_bus.tx_data = 8'hA5; u_bus.tx_valid = 1'b1;
    step();
    u_bus.tx_valid = 1'b0;
    n_checks++; if (tx !== 1'b1 || fifo_level !== 3'd1) $display("FAIL single_accept: got tx=%b level=%0d expected tx=1 level=1", tx, fifo_level); else n_pass++;
    step();
    n_checks++; if (tx !== 1'b0) $display("FAIL single_latency: got %b expected 0", tx); else n_pass++;
    record(FRAME_BITS * 8);
    errs = 0;
    for (int i = 0; i < 80; i++) if (rec[i] !== exp_tx(8'hA5, 8, i)) errs++;
    n_checks++; if (errs != 0) $display("FAIL single_wave: got %0d bad samples expected 0", errs); else n_pass++;
    for (int j = 0; j < 8; j++) dec[j] = rec[(j + 1) * 8 + 4];
    n_checks++; if (dec !== 8'hA5 || rec[4] !== 1'b0 || rec[76] !== 1'b1) $display("FAIL single_decode: got %h start=%b stop=%b expected a5 start=0 stop=1", dec, rec[4], rec[76]); else n_pass++;
    n_checks++; if (rec_busy[79] !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) $display("FAIL single_busy_end: got busy79=%b busy=%b tx=%b expected 1 0 1", rec_busy[79], busy, tx); else n_pass++;
    $display("single: byte a5 sent, decoded %h", dec);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    int errs;
    bytes[0] = 8'h3E; bytes[1] = 8'h44; bytes[2] = 8'h4A; bytes[3] = 8'h50;
    clk_div = 16'd8; enable = 1'b1; lvl_max = 0;
    u_bus.tx_data = bytes[0]; u_bus.tx_valid = 1'b1;
    step();
    u_bus.tx_data = bytes[1];
    step();
    for (int i = 0; i < 320; i++) begin
      if (i == 0) u_bus.tx_data = bytes[2];
      if (i == 1) u_bus.tx_data = bytes[3];
      if (i == 2) u_bus.tx_valid = 1'b0;
      rec[i] = tx;
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      step();
    end
    errs = 0;
    for (int i = 0; i < 320; i++) if (rec[i] !== exp_tx(bytes[i / 80], 8, i % 80)) errs++;
    n_checks++; if (errs != 0) $display("FAIL b2b_wave: got %0d bad samples expected 0", errs); else n_pass++;
    n_checks++; if (lvl_max != 3) $display("FAIL b2b_level_peak: got %0d expected 3", lvl_max); else n_pass++;
    n_checks++; if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL b2b_idle: got busy=%b tx=%b expected 0 1", busy, tx); else n_pass++;
    $display("back_to_back: 4 frames, level peak %0d", lvl_max);
  endtask

  task automatic test_full();
    logic [7:0] bytes [5];
    int errs;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    enable = 1'b0; clk_div = 16'd8;
    u_bus.tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      u_bus.tx_data = bytes[k];
      step();
    end
    n_checks++; if (u_bus.tx_ready !== 1'b0 || fifo_level !== 3'd4) $display("FAIL full_after4: got ready=%b level=%0d expected 0 4", u_bus.tx_ready, fifo_level); else n_pass++;
    u_bus.tx_data = bytes[4];
    step(); step();
    n_checks++; if (u_bus.tx_ready !== 1'b0 || fifo_level !== 3'd4 || tx !== 1'b1) $display("FAIL full_wait: got ready=%b level=%0d tx=%b expected 0 4 1", u_bus.tx_ready, fifo_level, tx); else n_pass++;
    enable = 1'b1;
    step();
    n_checks++; if (u_bus.tx_ready !== 1'b1 || fifo_level !== 3'd3 || tx !== 1'b0) $display("FAIL full_first_pop: got ready=%b level=%0d tx=%b expected 1 3 0", u_bus.tx_ready, fifo_level, tx); else n_pass++;
    step();
    u_bus.tx_valid = 1'b0;
    n_checks++; if (u_bus.tx_ready !== 1'b0 || fifo_level !== 3'd4) $display("FAIL full_fifth_accept: got ready=%b level=%0d expected 0 4", u_bus.tx_ready, fifo_level); else n_pass++;
    record(399);
    errs = 0;
    for (int i = 0; i < 399; i++) if (rec[i] !== exp_tx(bytes[(i + 1) / 80], 8, (i + 1) % 80)) errs++;
    n_checks++; if (errs != 0) $display("FAIL full_wave: got %0d bad samples expected 0", errs); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL full_drained: got busy=%b expected 0", busy); else n_pass++;
    $display("full: 5 bytes queued and sent in order");
  endtask

  task automatic test_clamp();
    int errs;
    enable = 1'b1; clk_div = 16'd1;
    u_bus.tx_data = 8'h96; u_bus.tx_valid = 1'b1;
    step();
    u_bus.tx_valid = 1'b0;
    step();
    n_checks++; if (tx !== 1'b0) $display("FAIL clamp_start: got %b expected 0", tx); else n_pass++;
    record(FRAME_BITS * 2);
    errs = 0;
    for (int i = 0; i < 20; i++) if (rec[i] !== exp_tx(8'h96, 2, i)) errs++;
    n_checks++; if (errs != 0 || busy !== 1'b0) $display("FAIL clamp_wave: got %0d bad samples busy=%b expected 0 0", errs, busy); else n_pass++;
    clk_div = 16'd8;
    $display("clamp: clk_div 1 gives 2-cycle bits");
  endtask

  task automatic test_div_sample();
    int errs;
    enable = 1'b1; clk_div = 16'd8;
    u_bus.tx_data = 8'hC3; u_bus.tx_valid = 1'b1;
    step();
    u_bus.tx_data = 8'h5A;
    step();
    for (int i = 0; i < 240; i++) begin
      if (i == 0) u_bus.tx_valid = 1'b0;
      if (i == 20) clk_div = 16'd16;
      rec[i] = tx;
      step();
    end
    errs = 0;
    for (int i = 0; i < 80; i++) if (rec[i] !== exp_tx(8'hC3, 8, i)) errs++;
    n_checks++; if (errs != 0) $display("FAIL div_current_frame: got %0d bad samples expected 0", errs); else n_pass++;
    errs = 0;
    for (int i = 80; i < 240; i++) if (rec[i] !== exp_tx(8'h5A, 16, i - 80)) errs++;
    n_checks++; if (errs != 0 || busy !== 1'b0) $display("FAIL div_next_frame: got %0d bad samples busy=%b expected 0 0", errs, busy); else n_pass++;
    clk_div = 16'd8;
    $display("div_sample: frame 1 at 8, frame 2 at 16");
  endtask

  task automatic test_reset_mid();
    int errs;
    int lows;
    enable = 1'b1; clk_div = 16'd8;
    u_bus.tx_data = 8'h37; u_bus.tx_valid = 1'b1;
    step();
    u_bus.tx_data = 8'hF0;
    step();
    for (int i = 0; i < 34; i++) begin
      if (i == 0) u_bus.tx_data = 8'hAA;
      if (i == 1) u_bus.tx_valid = 1'b0;
      step();
    end
    n_checks++; if (tx !== 1'b0 || fifo_level !== 3'd2) $display("FAIL rstmid_before: got tx=%b level=%0d expected 0 2", tx, fifo_level); else n_pass++;
    resetb = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1 || fifo_level !== 3'd0 || u_bus.tx_ready !== 1'b1) $display("FAIL rstmid_async: got tx=%b level=%0d ready=%b expected 1 0 1", tx, fifo_level, u_bus.tx_ready); else n_pass++;
    step(); step();
    resetb = 1'b1;
    step();
    n_checks++; if (fifo_level !== 3'd0 || u_bus.tx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rstmid_release: got level=%0d ready=%b busy=%b expected 0 1 0", fifo_level, u_bus.tx_ready, busy); else n_pass++;
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
      step();
    end
    n_checks++; if (lows != 0) $display("FAIL rstmid_no_resume: got %0d active cycles expected 0", lows); else n_pass++;
    u_bus.tx_data = 8'h81; u_bus.tx_valid = 1'b1;
    step();
    u_bus.tx_valid = 1'b0;
    step();
    record(80);
    errs = 0;
    for (int i = 0; i < 80; i++) if (rec[i] !== exp_tx(8'h81, 8, i)) errs++;
    n_checks++; if (errs != 0) $display("FAIL rstmid_new_frame: got %0d bad samples expected 0", errs); else n_pass++;
    $display("reset_mid: line released high, queue flushed");
  endtask

  task automatic test_enable_gate();
    int errs;
    int lows;
    enable = 1'b1; clk_div = 16'd8;
    u_bus.tx_data = 8'h12; u_bus.tx_valid = 1'b1;
    step();
    u_bus.tx_data = 8'h34;
    step();
    for (int i = 0; i < 80; i++) begin
      if (i == 0) u_bus.tx_valid = 1'b0;
      if (i == 74) enable = 1'b0;
      rec[i] = tx;
      step();
    end
    errs = 0;
    for (int i = 0; i < 80; i++) if (rec[i] !== exp_tx(8'h12, 8, i)) errs++;
    n_checks++; if (errs != 0) $display("FAIL gate_first_frame: got %0d bad samples expected 0", errs); else n_pass++;
    n_checks++; if (tx !== 1'b1 || busy !== 1'b1 || fifo_level !== 3'd1) $display("FAIL gate_idle: got tx=%b busy=%b level=%0d expected 1 1 1", tx, busy, fifo_level); else n_pass++;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1) lows++;
      step();
    end
    n_checks++; if (lows != 0) $display("FAIL gate_hold: got %0d low cycles expected 0", lows); else n_pass++;
    enable = 1'b1;
    step();
    n_checks++; if (tx !== 1'b0) $display("FAIL gate_resume: got %b expected 0", tx); else n_pass++;
    record(80);
    errs = 0;
    for (int i = 0; i < 80; i++) if (rec[i] !== exp_tx(8'h34, 8, i)) errs++;
    n_checks++; if (errs != 0 || busy !== 1'b0) $display("FAIL gate_second_frame: got %0d bad samples busy=%b expected 0 0", errs, busy); else n_pass++;
    $display("enable_gate: frame held then resumed");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 1'b0; enable = 1'b0; clk_div = 16'd8;
    u_bus.tx_valid = 1'b0; u_bus.tx_data = 8'h00;
    lvl_max = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_clamp();
    test_div_sample();
    test_reset_mid();
    test_enable_gate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/user_uart_tx.md
# user_uart_tx

Byte-wide 8N1 UART transmitter in the user project area. It drives a serial line routed to the management UART pin (mprj_io[6]), and the testbench UART monitor decodes that line. Firmware or logic-analyzer glue pushes bytes through a valid/ready port into a small FIFO. An FSM with a per-bit cycle counter serializes each byte LSB-first with one start bit and one stop bit.

## Interface
Parameters:
- FIFO_DEPTH, 4 — byte FIFO entries; power of two, minimum 2.
- DIV_W, 16 — width of the baud divisor input.

Ports:
- clock  in  1  — single system clock, rising edge.
- resetb  in  1  — asynchronous, active-low reset.
- enable  in  1  — permits a new frame to start; a frame in progress always completes.
- clk_div  in  DIV_W  — clock cycles per bit; values below 2 are treated as 2.
- tx_data  in  8  — byte to send.
- tx_valid  in  1  — tx_data is valid.
- tx_ready  out  1  — FIFO can accept a byte.
- tx  out  1  — serial output; idles high.
- busy  out  1  — high while a frame is on the line or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  — current FIFO occupancy.

## Operation
- Push: a byte is written on a rising edge where tx_valid && tx_ready.
- tx_ready = (fifo_level != FIFO_DEPTH). tx_ready is derived from occupancy before the edge, so a pop on the same edge as a full-FIFO condition does not raise tx_ready in that cycle.
- FSM states:
  - IDLE: tx = 1. If enable && FIFO non-empty: pop the head into the shift register, latch the effective clk_div into div_q, load the bit counter with div_q-1, and go to START.
  - START: tx = 0 for div_q cycles, then go to DATA with bit_idx = 0.
  - DATA: tx = shift[0] for div_q cycles per bit. Shift right after each bit. After bit_idx 7 completes, go to STOP.
  - STOP: tx = 1 for div_q cycles. Then:
    - if enable && FIFO non-empty: pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- clk_div is sampled only at frame start. Changing it mid-frame has no effect on the current frame.
- Simultaneous push and pop keeps fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Pushes while enable is low are accepted and queued.
- busy = (state != IDLE) || (fifo_level != 0).

## Timing
- Reset values: tx = 1, tx_ready = 1, busy = 0, fifo_level = 0, state = IDLE. FIFO contents are don't-care and the pointers are zeroed.
- Reset asserted mid-frame: tx goes to 1 asynchronously and the FIFO is flushed. No partial frame resumes after reset is released.
- Latency: with the FSM in IDLE, the FIFO empty and enable high, a byte accepted on edge k is popped on edge k+1. tx falls just after edge k+1.
- Frame length is exactly 10 × div_q cycles. Each bit boundary falls on a rising edge.
- tx, tx_ready, busy and fifo_level are all registered or decoded from registers; none is combinational from inputs.

## Structure
- Package user_uart_pkg holds:
  - the state enum {IDLE, START, DATA, STOP};
  - the constants FRAME_BITS = 10, DATA_BITS = 8, MIN_DIV = 2.
- Sub-module user_uart_tx_fifo: synchronous FIFO with the same clock and reset, push/pop/full/empty/level ports, parameterised by depth.
- The top level contains the FSM, the bit-cycle counter, the bit index and the shift register.

## Test plan
- Single byte: clk_div = 8, enable = 1, push 0xA5 → tx falls 1 cycle after the accept edge, then 0 | 1,0,1,0,0,1,0,1 | 1, each bit exactly 8 cycles; busy falls when STOP ends; the tbuart-style decoder reads 0xA5.
- Back-to-back: push 0x3E, 0x44, 0x4A, 0x50 in consecutive cycles, clk_div = 8 → 4 contiguous frames of 80 cycles each with no idle gap; fifo_level peaks at 3.
- Full FIFO: enable = 0, push 5 bytes with tx_valid held high → tx_ready drops after the 4th accept and the 5th byte waits. Raise enable → the first pop raises tx_ready the next cycle and the 5th byte is accepted.
- Divisor clamp and sampling: clk_div = 1 → bits last 2 cycles. Change clk_div from 8 to 16 mid-frame → the current frame keeps 8 cycles per bit and the next frame uses 16.
- Reset mid-frame: deassert resetb during DATA bit 3 with 2 bytes queued → tx = 1 immediately. After release: fifo_level = 0, tx_ready = 1, busy = 0, and no frame starts until a new push.
- Enable gating: drop enable during a STOP bit with bytes queued → the frame completes, the FSM idles with tx = 1, and transmission resumes 1 cycle after enable returns high.
